serial_addsub_deser: RTL and testbench
======================================

# serial_addsub_deser

Bit-serial adder/subtractor with a serial-in, parallel-out result path. It consumes two operand streams one bit per accepted cycle, LSB first, and computes a ± b a bit at a time with a registered carry. The result is reassembled into a parallel word, and the block pulses `done` when the word is ready. It sits at the receiving end of a serial operand link, as the counterpart of the parallel-in arithmetic unit, and returns parallel `sum`/`cout` to the datapath.

## Interface
- BIT, 8, operand and result width in bits; legal range is BIT ≥ 2.
- clk  in  1  clock; all state changes on the rising edge.
- nrst  in  1  reset, synchronous, active-low.
- start  in  1  begins an operation; sampled only in IDLE.
- addsub  in  1  0 selects add, 1 selects subtract; latched on an accepted start.
- bit_valid  in  1  a_bit/b_bit hold a valid operand bit this cycle.
- a_bit  in  1  serial operand a, LSB first.
- b_bit  in  1  serial operand b, LSB first.
- sum  out  BIT  parallel result; holds its value until the next completion.
- cout  out  1  final carry; holds its value until the next completion.
- done  out  1  one-cycle pulse when sum/cout have just been updated.
- busy  out  1  high while an operation is in progress (RUN).

## Operation
- FSM states:
  - IDLE → RUN on start.
  - RUN → IDLE on acceptance of the BIT-th valid bit.
- Internal registers: op (latched addsub), c (carry), cnt of width $clog2(BIT+1), sh (BIT-bit shift register).
- Accepted start (IDLE, start=1):
  - op←addsub, c←addsub, cnt←0, sh←0, busy←1.
  - For subtraction the carry-in is 1, so the datapath forms a + ~b + 1.
- Per accepted bit (RUN, bit_valid=1):
  - bb = b_bit ^ op.
  - s = a_bit ^ bb ^ c.
  - c ← majority(a_bit, bb, c).
  - sh ← {s, sh[BIT-1:1]}, shifting right with the new bit entering the MSB.
  - cnt ← cnt+1.
- Last bit (cnt == BIT-1 and bit_valid), on the same edge:
  - sum ← {s, sh[BIT-1:1]}.
  - cout ← carry out of that bit.
  - done ← 1, busy ← 0, state ← IDLE.
- cout semantics:
  - Add: unsigned carry out of a+b.
  - Subtract: carry out of a + ~b + 1, which equals 1 iff a ≥ b unsigned (no borrow).
- sum is modulo 2^BIT and is the same bit pattern for signed and unsigned interpretations.
- Boundary rules:
  - RUN with bit_valid=0: all state holds; gaps of any length are allowed.
  - start while busy: ignored; addsub is not re-latched.
  - bit_valid in IDLE, including the cycle start is sampled: the bit is ignored, and the first counted bit is sampled on the edge after start.
  - Reset asserted mid-operation: the operation is aborted with no done pulse; all registers and outputs return to reset values.
  - addsub changing during RUN: no effect.
- Reset values: sum=0, cout=0, done=0, busy=0, state=IDLE, c=0, cnt=0, sh=0.

## Timing
- done is registered:
  - It is high for exactly one cycle, the cycle after the edge that accepts the last bit.
  - sum/cout are valid in that same cycle and remain stable afterwards.
- With continuous bit_valid:
  - start is sampled at edge 0 and bits at edges 1..BIT.
  - done is high after edge BIT; latency is BIT+1 cycles from start to done.
- busy rises after the start edge and falls on the same edge done rises.
- Back-to-back operations: start may be asserted during the done cycle; it is accepted (state is IDLE), giving a throughput of BIT+1 cycles per operation.
- No combinational path from inputs to outputs.

## Test plan (BIT=8)
- Add with continuous bits: a=0x5A, b=0x3C → sum=0x96, cout=0, done exactly 9 cycles after start, busy high for 8 cycles.
- Add overflow: a=0xFF, b=0x01 → sum=0x00, cout=1; then a=0x00, b=0x00 back-to-back with start in the done cycle → sum=0x00, cout=0.
- Subtract: 0x20−0x10 → sum=0x10, cout=1; 0x10−0x20 → sum=0xF0, cout=0; 0x37−0x37 → sum=0x00, cout=1.
- Gapped stream: a=0xA5, b=0x5A, add, bit_valid deasserted 3 cycles after bits 2 and 6 → sum=0xFF, cout=0; done appears only after the 8th valid bit; toggling start and addsub mid-run has no effect.
- Reset mid-op: nrst low after 4 bits → sum, cout, done, busy all 0 the next cycle, no done pulse; a subsequent operation 0x01+0x01 → sum=0x02, cout=0.
- Idle noise: bit_valid pulses in IDLE with no start → sum/cout unchanged, done never asserts.

Source files
------------

// File: rtl/serial_addsub_deser_if.sv
// ---------------------------------------------------------------------------
// serial_addsub_deser_if
//   Signal bundle for the bit-serial adder/subtractor.
//   master : operand source (drives start/addsub/bit_valid/a_bit/b_bit,
//            observes sum/cout/done/busy)
//   slave  : the arithmetic block itself
//   Signals:
//     start     begin an operation (honoured only when idle)
//     addsub    0 = add, 1 = subtract (captured with start)
//     bit_valid a_bit/b_bit carry a valid operand bit this cycle
//     a_bit     serial operand a, LSB first
//     b_bit     serial operand b, LSB first
//     sum       parallel result word, held until the next completion
//     cout      final carry (add: carry out, subtract: 1 = no borrow)
//     done      one-cycle pulse when sum/cout have just been updated
//     busy      operation in progress
// ---------------------------------------------------------------------------
interface serial_addsub_deser_if #(
    parameter int BIT = 8
);
    logic           start;
    logic           addsub;
    logic           bit_valid;
    logic           a_bit;
    logic           b_bit;
    logic [BIT-1:0] sum;
    logic           cout;
    logic           done;
    logic           busy;

    modport master (
        output start,
        output addsub,
        output bit_valid,
        output a_bit,
        output b_bit,
        input  sum,
        input  cout,
        input  done,
        input  busy
    );

    modport slave (
        input  start,
        input  addsub,
        input  bit_valid,
        input  a_bit,
        input  b_bit,
        output sum,
        output cout,
        output done,
        output busy
    );
endinterface

// File: rtl/serial_addsub_deser.sv
// ---------------------------------------------------------------------------
// serial_addsub_deser
//   Bit-serial a +/- b with a registered carry. Operand bits arrive LSB
//   first, one per cycle with bit_valid high; result bits are collected in
//   a shift register and published as a parallel word together with the
//   final carry. done pulses for one cycle when sum/cout are refreshed.
//   Subtraction is formed as a + ~b + 1 (carry preset to 1, b inverted).
//
//   Ports:
//     clk   clock, rising edge
//     nrst  synchronous active-low reset
//     bus   serial_addsub_deser_if.slave (start/addsub/bit_valid/a_bit/b_bit
//           in; sum/cout/done/busy out)
//
//   All outputs come straight from registers.
// ---------------------------------------------------------------------------
module serial_addsub_deser #(
    parameter int BIT = 8
) (
    input  logic                  clk,
    input  logic                  nrst,
    serial_addsub_deser_if.slave  bus
);

    localparam int CNT_W = $clog2(BIT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic              op_reg,    op_next;
    logic              c_reg,     c_next;
    logic [CNT_W-1:0]  cnt_reg,   cnt_next;
    // Only BIT-1 result bits need to be stored: the final bit goes straight
    // into sum on the completing edge, so the oldest stored bit would never
    // be read again.
    logic [BIT-2:0]    sh_reg,    sh_next;
    logic [BIT-1:0]    sum_reg,   sum_next;
    logic              cout_reg,  cout_next;
    logic              done_reg,  done_next;

    // One full-adder slice on the current serial bit.
    logic              bb;
    logic              s_bit;
    logic              c_out;
    logic [BIT-2:0]    sh_shifted;

    assign bb    = bus.b_bit ^ op_reg;
    assign s_bit = bus.a_bit ^ bb ^ c_reg;
    assign c_out = (bus.a_bit & bb) | (bus.a_bit & c_reg) | (bb & c_reg);

    // Right shift with the new sum bit entering at the top.
    assign sh_shifted[BIT-2] = s_bit;
    generate
        for (genvar gi = 0; gi < BIT - 2; gi++) begin : g_shift
            assign sh_shifted[gi] = sh_reg[gi+1];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_reg <= IDLE;
            op_reg    <= 1'b0;
            c_reg     <= 1'b0;
            cnt_reg   <= '0;
            sh_reg    <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            c_reg     <= c_next;
            cnt_reg   <= cnt_next;
            sh_reg    <= sh_next;
            sum_reg   <= sum_next;
            cout_reg  <= cout_next;
            done_reg  <= done_next;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        c_next     = c_reg;
        cnt_next   = cnt_reg;
        sh_next    = sh_reg;
        sum_next   = sum_reg;
        cout_next  = cout_reg;
        done_next  = 1'b0;

        unique case (state_reg)
            IDLE: begin
                // bit_valid is deliberately ignored here, including on the
                // start cycle; the first counted bit comes on the next edge.
                if (bus.start) begin
                    state_next = RUN;
                    op_next    = bus.addsub;
                    c_next     = bus.addsub;
                    cnt_next   = '0;
                    sh_next    = '0;
                end
            end
            RUN: begin
                // start/addsub are not looked at while running.
                if (bus.bit_valid) begin
                    c_next   = c_out;
                    sh_next  = sh_shifted;
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == LAST_CNT) begin
                        sum_next   = {s_bit, sh_reg};
                        cout_next  = c_out;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.sum  = sum_reg;
    assign bus.cout = cout_reg;
    assign bus.done = done_reg;
    assign bus.busy = (state_reg == RUN);

endmodule

// File: tb/tb_serial_addsub_deser.sv
module tb_serial_addsub_deser;

    localparam int BIT = 8;

    logic clk = 1'b0;
    logic nrst = 1'b0;

    serial_addsub_deser_if #(.BIT(BIT)) bus_if ();

    serial_addsub_deser #(.BIT(BIT)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic       b2b;      // start issued in the done cycle of the previous op
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    // Runs one operation starting at a negedge; returns at the negedge of the
    // done cycle. bit_valid is high (with junk bits) on the start cycle, which
    // must be ignored. gap_mask[i] inserts 3 idle cycles after bit i.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                          input logic [7:0] gap_mask, input bit noise,
                          input logic [7:0] exp_sum, input logic exp_cout,
                          input string tag);
        int busy_cycles;
        int exp_busy;
        busy_cycles = 0;
        exp_busy = 8 + 3 * $countones(gap_mask[6:0]);
        bus_if.start     = 1'b1;
        bus_if.addsub    = sub;
        bus_if.bit_valid = 1'b1;
        bus_if.a_bit     = 1'b1;
        bus_if.b_bit     = 1'b1;
        @(posedge clk); @(negedge clk);
        bus_if.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus_if.busy) busy_cycles++;
            chk($sformatf("%s_no_done_bit%0d", tag, i), {31'b0, bus_if.done}, 32'd0);
            bus_if.bit_valid = 1'b1;
            bus_if.a_bit     = a[i];
            bus_if.b_bit     = b[i];
            if (noise) begin
                bus_if.start  = 1'b1;
                bus_if.addsub = ~sub;
            end
            @(posedge clk); @(negedge clk);
            bus_if.bit_valid = 1'b0;
            bus_if.start     = 1'b0;
            bus_if.addsub    = sub;
            if (i < 7 && gap_mask[i]) begin
                for (int g = 0; g < 3; g++) begin
                    if (bus_if.busy) busy_cycles++;
                    chk($sformatf("%s_gap_done_b%0d_g%0d", tag, i, g), {31'b0, bus_if.done}, 32'd0);
                    bus_if.a_bit = ~a[i];
                    bus_if.b_bit = ~b[i];
                    if (noise) begin
                        bus_if.start  = 1'b1;
                        bus_if.addsub = ~sub;
                    end
                    @(posedge clk); @(negedge clk);
                    bus_if.start  = 1'b0;
                    bus_if.addsub = sub;
                end
            end
        end
        chk({tag, "_done"}, {31'b0, bus_if.done}, 32'd1);
        chk({tag, "_busy_low"}, {31'b0, bus_if.busy}, 32'd0);
        chk({tag, "_sum"}, {24'b0, bus_if.sum}, {24'b0, exp_sum});
        chk({tag, "_cout"}, {31'b0, bus_if.cout}, {31'b0, exp_cout});
        chk({tag, "_busy_cycles"}, busy_cycles, exp_busy);
        $display("op %s a=%02h b=%02h sub=%0d -> sum=%02h cout=%0d", tag, a, b, sub,
                 bus_if.sum, bus_if.cout);
    endtask

    vec_t vecs[8];

    initial begin
        logic [7:0] held_sum;
        logic       held_cout;

        vecs[0] = '{a: 8'h5A, b: 8'h3C, sub: 1'b0, b2b: 1'b0, exp_sum: 8'h96, exp_cout: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, b2b: 1'b0, exp_sum: 8'h00, exp_cout: 1'b1};
        vecs[2] = '{a: 8'h00, b: 8'h00, sub: 1'b0, b2b: 1'b1, exp_sum: 8'h00, exp_cout: 1'b0};
        vecs[3] = '{a: 8'h20, b: 8'h10, sub: 1'b1, b2b: 1'b0, exp_sum: 8'h10, exp_cout: 1'b1};
        vecs[4] = '{a: 8'h10, b: 8'h20, sub: 1'b1, b2b: 1'b0, exp_sum: 8'hF0, exp_cout: 1'b0};
        vecs[5] = '{a: 8'h37, b: 8'h37, sub: 1'b1, b2b: 1'b0, exp_sum: 8'h00, exp_cout: 1'b1};
        vecs[6] = '{a: 8'h80, b: 8'h80, sub: 1'b0, b2b: 1'b1, exp_sum: 8'h00, exp_cout: 1'b1};
        vecs[7] = '{a: 8'h00, b: 8'h01, sub: 1'b1, b2b: 1'b0, exp_sum: 8'hFF, exp_cout: 1'b0};

        bus_if.start     = 1'b0;
        bus_if.addsub    = 1'b0;
        bus_if.bit_valid = 1'b0;
        bus_if.a_bit     = 1'b0;
        bus_if.b_bit     = 1'b0;
        nrst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_sum",  {24'b0, bus_if.sum}, 32'd0);
        chk("reset_cout", {31'b0, bus_if.cout}, 32'd0);
        chk("reset_done", {31'b0, bus_if.done}, 32'd0);
        chk("reset_busy", {31'b0, bus_if.busy}, 32'd0);
        nrst = 1'b1;
        @(posedge clk); @(negedge clk);

        // Table-driven vectors.
        for (int v = 0; v < 8; v++) begin
            run_op(vecs[v].a, vecs[v].b, vecs[v].sub, 8'h00, 1'b0,
                   vecs[v].exp_sum, vecs[v].exp_cout, $sformatf("vec%0d", v));
            if (!(v < 7 && vecs[v+1].b2b)) begin
                @(posedge clk); @(negedge clk);
                chk($sformatf("vec%0d_done_one_cycle", v), {31'b0, bus_if.done}, 32'd0);
                chk($sformatf("vec%0d_sum_hold", v), {24'b0, bus_if.sum}, {24'b0, vecs[v].exp_sum});
                chk($sformatf("vec%0d_cout_hold", v), {31'b0, bus_if.cout}, {31'b0, vecs[v].exp_cout});
            end
        end

        // Gapped stream with start/addsub toggling mid-run.
        run_op(8'hA5, 8'h5A, 1'b0, 8'b0100_0100, 1'b1, 8'hFF, 1'b0, "gapped");
        @(posedge clk); @(negedge clk);
        chk("gapped_done_one_cycle", {31'b0, bus_if.done}, 32'd0);
        chk("gapped_busy_idle", {31'b0, bus_if.busy}, 32'd0);

        // Reset in the middle of an operation.
        bus_if.start = 1'b1; bus_if.addsub = 1'b0;
        @(posedge clk); @(negedge clk);
        bus_if.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_if.bit_valid = 1'b1; bus_if.a_bit = 1'b1; bus_if.b_bit = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        bus_if.bit_valid = 1'b0;
        chk("midop_busy", {31'b0, bus_if.busy}, 32'd1);
        nrst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rst_mid_sum",  {24'b0, bus_if.sum}, 32'd0);
        chk("rst_mid_cout", {31'b0, bus_if.cout}, 32'd0);
        chk("rst_mid_done", {31'b0, bus_if.done}, 32'd0);
        chk("rst_mid_busy", {31'b0, bus_if.busy}, 32'd0);
        nrst = 1'b1;
        // Stray bits after reset must not complete the aborted operation.
        for (int i = 0; i < 6; i++) begin
            bus_if.bit_valid = 1'b1; bus_if.a_bit = 1'b1; bus_if.b_bit = 1'b0;
            @(posedge clk); @(negedge clk);
            chk($sformatf("post_rst_no_done%0d", i), {31'b0, bus_if.done}, 32'd0);
        end
        bus_if.bit_valid = 1'b0;
        run_op(8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0, "after_rst");
        @(posedge clk); @(negedge clk);

        // Idle noise: bit_valid pulses with no start.
        held_sum  = bus_if.sum;
        held_cout = bus_if.cout;
        chk("idle_held_sum_is_result", {24'b0, held_sum}, 32'h02);
        for (int i = 0; i < 10; i++) begin
            bus_if.bit_valid = i[0];
            bus_if.a_bit     = 1'b1;
            bus_if.b_bit     = i[1];
            @(posedge clk); @(negedge clk);
            chk($sformatf("idle_done%0d", i), {31'b0, bus_if.done}, 32'd0);
            chk($sformatf("idle_busy%0d", i), {31'b0, bus_if.busy}, 32'd0);
            chk($sformatf("idle_sum%0d", i), {24'b0, bus_if.sum}, {24'b0, held_sum});
            chk($sformatf("idle_cout%0d", i), {31'b0, bus_if.cout}, {31'b0, held_cout});
        end
        bus_if.bit_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
